// File: rtl/genreg_bus_master.sv
// Initiator for the generic register bus: turns host read/write burst commands into one-cycle
// select strobes. Optional fixed-address bursts are enabled by the macro GENREG_FIXED_ADDR_EN.
module genreg_bus_master #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_len,
`ifdef GENREG_FIXED_ADDR_EN
    input  logic        cmd_fixed,
`endif
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic [31:0] rdata,
    output logic        rdata_last,
    output logic [31:0] addr_ctrl,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic [7:0]  debug
);

    // Every host stream (cmd, wdata, rdata) transfers on a rising edge where valid and
    // ready are both high; valid never waits on ready, and the sender holds its payload until then.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        STROBE  = 3'd2,
        RD_WAIT = 3'd3,
        RSP     = 3'd4
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

    state_t      state;
    logic [15:0] addr;
    logic        rd;
    logic        fixed;
    logic [7:0]  beats_left;
    logic [1:0]  lat_cnt;
    logic [15:0] next_addr;

    assign cmd_ready = (state == IDLE);
    assign next_addr = fixed ? addr : addr + 16'd1;
    assign debug     = {state, 1'b0, beats_left[3:0]};

`ifdef GENREG_FIXED_ADDR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fixed <= 1'b0;
        else if (state == IDLE && cmd_valid)
            fixed <= cmd_fixed;
    end
`else
    assign fixed = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= 16'd0;
            rd          <= 1'b0;
            beats_left  <= 8'd0;
            lat_cnt     <= 2'd0;
            addr_ctrl   <= 32'd0;
            bus_wdata   <= 32'd0;
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            wdata_ready <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr       <= cmd_addr;
                        rd         <= cmd_rd;
                        beats_left <= cmd_len;
                        busy       <= 1'b1;
                        if (cmd_rd) begin
                            addr_ctrl <= {cmd_addr, 14'd0, 2'b11};
                            state     <= STROBE;
                        end else begin
                            wdata_ready <= 1'b1;
                            state       <= WR_WAIT;
                        end
                    end
                end
                WR_WAIT: begin
                    if (wdata_valid) begin
                        bus_wdata   <= wdata;
                        addr_ctrl   <= {addr, 14'd0, 2'b01};
                        wdata_ready <= 1'b0;
                        state       <= STROBE;
                    end
                end
                STROBE: begin
                    // Select lives for exactly this one cycle; the address/direction bits stay put.
                    addr_ctrl[0] <= 1'b0;
                    if (rd) begin
                        lat_cnt <= LAT_INIT;
                        state   <= RD_WAIT;
                    end else if (beats_left == 8'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        addr        <= next_addr;
                        beats_left  <= beats_left - 8'd1;
                        wdata_ready <= 1'b1;
                        state       <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rdata       <= bus_rdata;
                        rdata_valid <= 1'b1;
                        rdata_last  <= (beats_left == 8'd0);
                        state       <= RSP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RSP: begin
                    if (rdata_ready) begin
                        rdata_valid <= 1'b0;
                        rdata_last  <= 1'b0;
                        if (beats_left == 8'd0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            addr       <= next_addr;
                            beats_left <= beats_left - 8'd1;
                            addr_ctrl  <= {next_addr, 14'd0, 2'b11};
                            state      <= STROBE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genreg_bus_master.sv
// Randomized bench for genreg_bus_master: a register-bank responder, a per-beat expectation
// model of strobes and read responses, and directed boundary scenarios.
module tb_genreg_bus_master;

  localparam int RD_LATENCY = 1;
  localparam int LIM = 5000;

  typedef struct packed {
    logic [15:0] a;
    logic        rd;
    logic [31:0] d;
  } strobe_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rd = 1'b0;
  logic [15:0] cmd_addr = 16'd0;
  logic [7:0]  cmd_len = 8'd0;
`ifdef GENREG_FIXED_ADDR_EN
  logic        cmd_fixed = 1'b0;
`endif
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = 32'd0;
  logic        rdata_valid;
  logic        rdata_ready = 1'b0;
  logic [31:0] rdata;
  logic        rdata_last;
  logic [31:0] addr_ctrl;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'd0;
  logic        busy;
  logic [7:0]  debug;

  int checks = 0;
  int errors = 0;

  strobe_t     exp_strobe[$];
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] bus_mem[int];
  logic        rd_auto = 1'b1;

  genreg_bus_master #(.RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef GENREG_FIXED_ADDR_EN
    .cmd_fixed(cmd_fixed),
`endif
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .addr_ctrl(addr_ctrl), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .busy(busy), .debug(debug)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {16'hA5C3, a};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // responder: samples select on the rising edge, read data valid one cycle later
  always @(posedge clk) begin
    if (!reset && addr_ctrl[0]) begin
      if (addr_ctrl[1])
        bus_rdata <= bus_mem.exists(int'(addr_ctrl[31:16])) ? bus_mem[int'(addr_ctrl[31:16])]
                                                             : dflt(addr_ctrl[31:16]);
      else
        bus_mem[int'(addr_ctrl[31:16])] = bus_wdata;
    end
  end

  // host read-ready driver
  initial begin
    forever begin
      @(negedge clk);
      if (rd_auto) rdata_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard: strobes and read responses
  logic        prev_sel = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = 32'd0;
  int          rd_strobe_cyc = 0;
  int          strobe_seen = 0;
  strobe_t     s;
  logic [32:0] r;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_sel = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (addr_ctrl[0]) begin
        strobe_seen++;
        check("sel_twice", 32'(prev_sel), 32'd0);
        check("ctrl_zero", 32'(addr_ctrl[15:2]), 32'd0);
        if (exp_strobe.size() == 0) begin
          check("strobe_extra", 32'(addr_ctrl[0]), 32'd0);
        end else begin
          s = exp_strobe.pop_front();
          check("strobe_addr", 32'(addr_ctrl[31:16]), 32'(s.a));
          check("strobe_rd", 32'(addr_ctrl[1]), 32'(s.rd));
          if (!s.rd) check("strobe_wdata", bus_wdata, s.d);
          else rd_strobe_cyc = cyc;
        end
      end
      if (rdata_valid) begin
        if (!prev_valid) check("rd_latency", 32'(cyc - rd_strobe_cyc), 32'(RD_LATENCY + 1));
        if (prev_valid && !prev_ready) begin
          check("rsp_hold_data", rdata, prev_data);
          check("rsp_hold_last", 32'(rdata_last), 32'(prev_last));
        end
        if (rdata_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_extra", 32'(rdata_valid), 32'd0);
          end else begin
            r = exp_q.pop_front();
            check("rsp_data", rdata, r[31:0]);
            check("rsp_last", 32'(rdata_last), 32'(r[32]));
          end
        end
      end
      prev_sel = addr_ctrl[0];
      prev_valid = rdata_valid;
      prev_ready = rdata_ready;
      prev_data = rdata;
      prev_last = rdata_last;
    end
  end

  // driver tasks
  task automatic push_wdata(input logic [31:0] d);
    int n;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    wdata_valid = 1'b1;
    wdata = d;
    n = 0;
    while (!wdata_ready && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) check("wdata_timeout", 32'(wdata_ready), 32'd1);
    @(negedge clk);
    wdata_valid = 1'b0;
    wdata = $urandom;
  endtask

  task automatic do_cmd(input logic rdf, input logic [15:0] a, input logic [7:0] len,
                        input logic fx, input logic [31:0] d0);
    logic [15:0] ba;
    logic [31:0] d;
    logic [31:0] wd[$];
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      ba = fx ? a : a + 16'(i);
      if (rdf) begin
        exp_strobe.push_back({ba, 1'b1, 32'd0});
        exp_q.push_back({(i == int'(len)), ref_rd(ba)});
      end else begin
        d = (i == 0) ? d0 : $urandom;
        exp_strobe.push_back({ba, 1'b0, d});
        ref_mem[int'(ba)] = d;
        wd.push_back(d);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rd = rdf;
    cmd_addr = a;
    cmd_len = len;
`ifdef GENREG_FIXED_ADDR_EN
    cmd_fixed = fx;
`endif
    n = 0;
    while (!cmd_ready && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) check("cmd_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rd = $urandom;
    cmd_addr = $urandom;
    cmd_len = $urandom;
    foreach (wd[i]) push_wdata(wd[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_strobe.size() != 0 || exp_q.size() != 0) && n < LIM) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= LIM) check("idle_timeout", 32'(busy) + 32'(exp_strobe.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, base;
    logic rdf, fx;
    logic [15:0] a;
    logic [7:0] len;

    ref_mem[1] = 32'h12345678;
    bus_mem[1] = 32'h12345678;

    #3;
    check("rst_addr_ctrl", addr_ctrl, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_rdata_last", 32'(rdata_last), 32'd0);
    check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_debug", 32'(debug), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // single write at 0x0000
    do_cmd(1'b0, 16'h0000, 8'd0, 1'b0, 32'hDEADBEEF);
    check("wr0_ctrl", addr_ctrl, 32'h00000001);
    check("wr0_wdata", bus_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("wr0_busy_done", 32'(busy), 32'd0);
    wait_idle();

    // single read at 0x0001
    do_cmd(1'b1, 16'h0001, 8'd0, 1'b0, 32'd0);
    check("rd1_ctrl", addr_ctrl, 32'h00010003);
    wait_idle();

    // read burst with a 5-cycle stall on the first response
    rd_auto = 1'b0;
    rdata_ready = 1'b0;
    do_cmd(1'b1, 16'h0005, 8'd3, 1'b0, 32'd0);
    n = 0;
    while (!rdata_valid && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) check("stall_timeout", 32'(rdata_valid), 32'd1);
    repeat (5) @(negedge clk);
    check("stall_valid", 32'(rdata_valid), 32'd1);
    rdata_ready = 1'b1;
    rd_auto = 1'b1;
    wait_idle();

    // write burst across the address wrap, then read it back
    do_cmd(1'b0, 16'hFFFF, 8'd1, 1'b0, $urandom);
    wait_idle();
    do_cmd(1'b1, 16'hFFFF, 8'd1, 1'b0, 32'd0);
    wait_idle();

    // reset during RD_WAIT of beat 2 of 4
    rd_auto = 1'b0;
    rdata_ready = 1'b1;
    base = strobe_seen;
    do_cmd(1'b1, 16'h0100, 8'd3, 1'b0, 32'd0);
    n = 0;
    while (strobe_seen < base + 2 && n < LIM) begin @(negedge clk); #2; n++; end
    if (n >= LIM) check("rst_burst_timeout", 32'(strobe_seen), 32'(base + 2));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ctrl", addr_ctrl, 32'd0);
    check("mid_rst_valid", 32'(rdata_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_strobe.delete();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_state", 32'(debug[7:5]), 32'd0);
    rd_auto = 1'b1;

`ifdef GENREG_FIXED_ADDR_EN
    do_cmd(1'b1, 16'h0001, 8'd2, 1'b1, 32'd0);
    wait_idle();
    do_cmd(1'b0, 16'h0040, 8'd3, 1'b1, $urandom);
    wait_idle();
    do_cmd(1'b1, 16'h0040, 8'd0, 1'b0, 32'd0);
    wait_idle();
`endif

    // full-length burst
    do_cmd(1'b1, 16'hFF80, 8'd255, 1'b0, 32'd0);
    wait_idle();

    // random traffic; commands sometimes arrive while the master is still busy
    for (int k = 0; k < 30; k++) begin
      rdf = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 63));
      len = 8'($urandom_range(0, 7));
`ifdef GENREG_FIXED_ADDR_EN
      fx = 1'($urandom_range(0, 1));
`else
      fx = 1'b0;
`endif
      do_cmd(rdf, a, len, fx, $urandom);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
